// File: rtl/mdu_pkg.sv
// mdu_pkg: shared multiply/divide unit encodings and limits.
package mdu_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011
  } mul_op_t;
  localparam int MUL_MAX_STAGES = 4;
endpackage

// File: rtl/mul_pipe_if.sv
// mul_pipe_if: operand/hazard/result bundle between the MDU pipeline and its surroundings.
interface mul_pipe_if #(parameter int XLEN = 32);
  logic              Stall;
  logic              Flush;
  logic              ValidIn;
  logic [2:0]        Funct3;
  logic [XLEN-1:0]   SrcA;
  logic [XLEN-1:0]   SrcB;
  logic              ValidOut;
  logic [2*XLEN-1:0] ProdOut;
  logic [XLEN-1:0]   Result;
  logic              Busy;
  modport master (output Stall, Flush, ValidIn, Funct3, SrcA, SrcB,
                  input  ValidOut, ProdOut, Result, Busy);
  modport slave  (input  Stall, Flush, ValidIn, Funct3, SrcA, SrcB,
                  output ValidOut, ProdOut, Result, Busy);
endinterface

// File: rtl/flopenrc.sv
// flopenrc: enabled register with synchronous clear and asynchronous active-low reset.
module flopenrc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/mul_ppgen.sv
// mul_ppgen: four signed partial products whose sum is the RV M-extension product.
module mul_ppgen
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   SrcA,
  input  logic [XLEN-1:0]   SrcB,
  input  logic [2:0]        Funct3,
  output logic [2*XLEN-1:0] pp1,
  output logic [2*XLEN-1:0] ppa,
  output logic [2*XLEN-1:0] ppb,
  output logic [2*XLEN-1:0] ppm
);
  localparam int W = 2 * XLEN;
  logic [W-1:0] a_l, b_l, pa, pb, pm;
  logic         a_m, b_m, rsv;
  always_comb begin
    a_m = SrcA[XLEN-1];
    b_m = SrcB[XLEN-1];
    a_l = {{(XLEN+1){1'b0}}, SrcA[XLEN-2:0]};
    b_l = {{(XLEN+1){1'b0}}, SrcB[XLEN-2:0]};
    pa  = a_m ? b_l << (XLEN-1) : '0;
    pb  = b_m ? a_l << (XLEN-1) : '0;
    pm  = {1'b0, a_m & b_m, {(W-2){1'b0}}};
    // Reserved encodings yield a zero product while still travelling as valid
    rsv = Funct3[2];
    pp1 = rsv ? '0 : a_l * b_l;
    ppa = rsv ? '0 : (Funct3 == OP_MULH || Funct3 == OP_MULHSU) ? -pa : pa;
    ppb = rsv ? '0 : (Funct3 == OP_MULH) ? -pb : pb;
    ppm = rsv ? '0 : (Funct3 == OP_MULHSU) ? -pm : pm;
  end
endmodule

// File: rtl/mul_pipe.sv
// mul_pipe: STAGES-deep RV M-extension multiplier carrying valid and Funct3 with the data.
module mul_pipe
  import mdu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2
) (
  input logic       clk,
  input logic       reset,
  mul_pipe_if.slave bus
);
  localparam int W  = 2 * XLEN;
  localparam int PW = W + 4;
  logic [W-1:0]      pp1, ppa, ppb, ppm;
  logic [STAGES-1:0] vld;
  logic [PW-1:0]     out_q;
  logic              en;
  assign en = ~bus.Stall;
  mul_ppgen #(.XLEN(XLEN)) u_ppgen (
    .SrcA(bus.SrcA), .SrcB(bus.SrcB), .Funct3(bus.Funct3),
    .pp1(pp1), .ppa(ppa), .ppb(ppb), .ppm(ppm)
  );
  if (STAGES == 1) begin : g_one
    logic [PW-1:0] s_d;
    always_comb s_d = {bus.ValidIn, bus.Funct3, pp1 + ppa + ppb + ppm};
    flopenrc #(.W(PW)) u_s (.clk(clk), .reset(reset), .en(en), .clr(bus.Flush), .d(s_d), .q(out_q));
    assign vld[0] = out_q[PW-1];
  end else begin : g_multi
    logic [4*W+3:0] s1_d, s1_q;
    logic [PW-1:0]  s2_d;
    logic [PW-1:0]  s_q [2:STAGES];
    always_comb begin
      s1_d = {bus.ValidIn, bus.Funct3, pp1, ppa, ppb, ppm};
      s2_d = {s1_q[4*W+3:4*W],
              s1_q[4*W-1:3*W] + s1_q[3*W-1:2*W] + s1_q[2*W-1:W] + s1_q[W-1:0]};
    end
    flopenrc #(.W(4*W+4)) u_s1 (.clk(clk), .reset(reset), .en(en), .clr(bus.Flush), .d(s1_d), .q(s1_q));
    flopenrc #(.W(PW)) u_s2 (.clk(clk), .reset(reset), .en(en), .clr(bus.Flush), .d(s2_d), .q(s_q[2]));
    for (genvar i = 3; i <= STAGES; i++) begin : g_dly
      flopenrc #(.W(PW)) u_s (.clk(clk), .reset(reset), .en(en), .clr(bus.Flush), .d(s_q[i-1]), .q(s_q[i]));
    end
    for (genvar i = 2; i <= STAGES; i++) begin : g_vld
      assign vld[i-1] = s_q[i][PW-1];
    end
    assign vld[0] = s1_q[4*W+3];
    assign out_q  = s_q[STAGES];
  end
  always_comb begin
    bus.ValidOut = out_q[PW-1];
    bus.ProdOut  = out_q[W-1:0];
    bus.Result   = (out_q[W+2:W] == OP_MUL) ? out_q[XLEN-1:0] : out_q[W-1:XLEN];
    bus.Busy     = |vld;
  end
endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: directed checks of mul_pipe at XLEN=32/STAGES=2 and XLEN=64/STAGES=4.
module tb_mul_pipe;
  import mdu_pkg::*;
  logic clk, reset;
  int   n_run, n_fail;
  mul_pipe_if #(.XLEN(32)) ia ();
  mul_pipe_if #(.XLEN(64)) ib ();
  mul_pipe #(.XLEN(32), .STAGES(2)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  mul_pipe #(.XLEN(64), .STAGES(4)) dut_b (.clk(clk), .reset(reset), .bus(ib));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive_a(input logic v, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    ia.ValidIn = v; ia.Funct3 = f; ia.SrcA = x; ia.SrcB = y;
  endtask
  task automatic drive_b(input logic v, input logic [2:0] f, input logic [63:0] x, input logic [63:0] y);
    ib.ValidIn = v; ib.Funct3 = f; ib.SrcA = x; ib.SrcB = y;
  endtask
  // Called one capture edge after issue; n counts edges from capture until ValidOut.
  task automatic wait_a(inout int n);
    while (!ia.ValidOut && n < 16) begin @(negedge clk); n++; end
  endtask
  task automatic wait_b(inout int n);
    while (!ib.ValidOut && n < 16) begin @(negedge clk); n++; end
  endtask
  task automatic op_a(input string tag, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                      input logic [63:0] prod, input logic [31:0] res);
    int n;
    drive_a(1, f, x, y);
    @(negedge clk);
    drive_a(0, 0, 0, 0);
    n = 1;
    wait_a(n);
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_prod"}, ia.ProdOut, prod);
    chk({tag, "_res"}, ia.Result, res);
    @(negedge clk);
  endtask
  task automatic op_b(input string tag, input logic [2:0] f, input logic [63:0] x, input logic [63:0] y,
                      input logic [127:0] prod, input logic [63:0] res);
    int n;
    drive_b(1, f, x, y);
    @(negedge clk);
    drive_b(0, 0, 0, 0);
    n = 1;
    wait_b(n);
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_prod"}, ib.ProdOut, prod);
    chk({tag, "_res"}, ib.Result, res);
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int  n;
    logic seen;
    n_run = 0; n_fail = 0;
    reset = 0;
    ia.Stall = 0; ia.Flush = 0; ib.Stall = 0; ib.Flush = 0;
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    @(negedge clk); @(negedge clk);
    chk("rst_a", {ia.ValidOut, ia.Busy, ia.ProdOut, ia.Result}, '0);
    chk("rst_b", {ib.ValidOut, ib.Busy, ib.ProdOut, ib.Result}, '0);
    reset = 1;
    @(negedge clk);
    drive_a(1, OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    drive_a(0, 0, 0, 0);
    chk("mulh_early_valid", ia.ValidOut, 0);
    chk("mulh_busy", ia.Busy, 1);
    n = 1;
    wait_a(n);
    chk("mulh_lat", n, 2);
    chk("mulh_prod", ia.ProdOut, 64'h0000000000000001);
    chk("mulh_res", ia.Result, 32'h00000000);
    @(negedge clk);
    op_a("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF00000001, 32'hFFFFFFFF);
    op_a("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'hFFFFFFFE);
    op_a("mulh_mix", OP_MULH, 32'hFFFFFFF9, 32'h00000003, 64'hFFFFFFFFFFFFFFEB, 32'hFFFFFFFF);
    op_a("rsv", 3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 32'h0);
    // Back-to-back MUL, one per cycle
    drive_a(1, OP_MUL, 32'h80000000, 32'h80000000);
    @(negedge clk);
    drive_a(1, OP_MUL, 32'h00000007, 32'hFFFFFFFD);
    @(negedge clk);
    drive_a(0, 0, 0, 0);
    chk("b2b1_valid", ia.ValidOut, 1);
    chk("b2b1_prod", ia.ProdOut, 64'h4000000000000000);
    chk("b2b1_res", ia.Result, 32'h0);
    @(negedge clk);
    chk("b2b2_valid", ia.ValidOut, 1);
    chk("b2b2_prod", ia.ProdOut, 64'h00000006FFFFFFEB);
    chk("b2b2_res", ia.Result, 32'hFFFFFFEB);
    @(negedge clk);
    // Stall for three cycles with the op in stage 1; new operands must be ignored
    drive_a(1, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    drive_a(1, OP_MUL, 32'h5, 32'h5);
    ia.Stall = 1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); seen |= ia.ValidOut; end
    chk("stall_frozen", seen, 0);
    chk("stall_busy", ia.Busy, 1);
    ia.Stall = 0;
    drive_a(0, 0, 0, 0);
    n = 4;
    wait_a(n);
    chk("stall_lat", n, 5);
    chk("stall_prod", ia.ProdOut, 64'hFFFFFFFE00000001);
    @(negedge clk);
    chk("stall_no_extra", ia.ValidOut, 0);
    // Flush with Stall and two ops in flight
    drive_a(1, OP_MUL, 32'h3, 32'h4);
    @(negedge clk);
    drive_a(1, OP_MUL, 32'h5, 32'h6);
    @(negedge clk);
    drive_a(1, OP_MUL, 32'h7, 32'h8);
    ia.Flush = 1; ia.Stall = 1;
    @(negedge clk);
    ia.Flush = 0; ia.Stall = 0;
    drive_a(0, 0, 0, 0);
    chk("flush_valid", ia.ValidOut, 0);
    chk("flush_busy", ia.Busy, 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); seen |= ia.ValidOut | ia.Busy; end
    chk("flush_none", seen, 0);
    // Asynchronous reset between edges with work in flight
    drive_a(1, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    @(negedge clk);
    drive_a(0, 0, 0, 0);
    chk("pre_rst_valid", ia.ValidOut, 1);
    #1 reset = 0;
    #1;
    chk("mid_rst", {ia.ValidOut, ia.Busy, ia.ProdOut, ia.Result}, '0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("post_rst_busy", ia.Busy, 0);
    op_b("mulh64", OP_MULH, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 128'h1, 64'h0);
    op_b("mulhu64", OP_MULHU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
         128'hFFFFFFFFFFFFFFFE0000000000000001, 64'hFFFFFFFFFFFFFFFE);
    op_b("mul64", OP_MUL, 64'h7, 64'hFFFFFFFFFFFFFFFD,
         128'h0000000000000006FFFFFFFFFFFFFFEB, 64'hFFFFFFFFFFFFFFEB);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
